memory_interface: RTL and testbench

- Memory-side stage directly downstream of control_logic.
- Consumes mio_en and r_w from the control word, plus MAR/MDR contents from the datapath.
- Sequences one access to a synchronous single-port RAM with a programmable number of wait states.
- Returns ready_bit to the microsequencer, and read data to the MDR input mux, so memory states 33/28/16/… spin until the access completes.

---
 rtl/memory_interface_if.sv | 27 ++
 rtl/memory_interface.sv | 97 +++++++++
 tb/tb_memory_interface.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_interface_if.sv
// rtl/memory_interface_if.sv - synchronous single-port RAM bus between memory_interface and the RAM
interface memory_interface_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/memory_interface.sv
// rtl/memory_interface.sv - sequences one RAM access with programmable wait states and returns ready_bit
module memory_interface #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mio_en,
    input  logic                r_w,
    input  logic [ADDR_W-1:0]   mar,
    input  logic [DATA_W-1:0]   mdr_in,
    output logic                ready_bit,
    output logic [DATA_W-1:0]   rd_data,
    memory_interface_if.master  mem
);

    if (WAIT_STATES < 2 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("memory_interface: WAIT_STATES must be within 2..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;

    // State register; reset aborts any in-flight access immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept only in IDLE, leave BUSY on the last wait edge, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mio_en) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the request, pulse the RAM strobe once, count waits, capture read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= 4'd0;
            ready_bit     <= 1'b0;
            rd_data       <= '0;
            mem.mem_en    <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            mem.mem_en <= 1'b0;
            // Registered so ready_bit is high exactly while state is DONE.
            ready_bit  <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (mio_en) begin
                        mem.mem_en    <= 1'b1;
                        mem.mem_we    <= r_w;
                        mem.mem_addr  <= mar;
                        mem.mem_wdata <= mdr_in;
                        cnt           <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                    // mem_we doubles as the latched read/write flag for the whole access.
                    if (cnt == 4'd1 && !mem.mem_we) begin
                        rd_data <= mem.mem_rdata;
                    end
                end
                DONE: begin
                    mem.mem_we <= 1'b0;
                end
                default: begin
                    mem.mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_interface.sv
// tb/tb_memory_interface.sv - directed self-checking bench for memory_interface
module tb_memory_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic        mio_en_a, r_w_a, ready_a;
    logic [15:0] mar_a, mdr_a, rd_a;
    logic        mio_en_b, r_w_b, ready_b;
    logic [15:0] mar_b, mdr_b, rd_b;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] rdy_mask;
    logic [15:0] en_mask;
    int          wr_before;

    always #5 clk = ~clk;

    memory_interface_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
    memory_interface_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

    memory_interface #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(3)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .mio_en    (mio_en_a),
        .r_w       (r_w_a),
        .mar       (mar_a),
        .mdr_in    (mdr_a),
        .ready_bit (ready_a),
        .rd_data   (rd_a),
        .mem       (bus_a.master)
    );

    memory_interface #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(2)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .mio_en    (mio_en_b),
        .r_w       (r_w_b),
        .mar       (mar_b),
        .mdr_in    (mdr_b),
        .ready_bit (ready_b),
        .rd_data   (rd_b),
        .mem       (bus_b.master)
    );

    logic [15:0] ram_a [0:65535];
    logic [15:0] ram_b [0:65535];
    int          wr_cnt_a = 0;
    int          wr_cnt_b = 0;

    // Synchronous RAM models: read data registered one edge after the strobe.
    always @(posedge clk) begin
        if (bus_a.mem_en) begin
            if (bus_a.mem_we) begin
                ram_a[bus_a.mem_addr] <= bus_a.mem_wdata;
                wr_cnt_a <= wr_cnt_a + 1;
            end else begin
                bus_a.mem_rdata <= ram_a[bus_a.mem_addr];
            end
        end
        if (bus_b.mem_en) begin
            if (bus_b.mem_we) begin
                ram_b[bus_b.mem_addr] <= bus_b.mem_wdata;
                wr_cnt_b <= wr_cnt_b + 1;
            end else begin
                bus_b.mem_rdata <= ram_b[bus_b.mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ram_a[16'h3000] <= 16'hBEEF;
        ram_a[16'h5000] <= 16'h5555;
        ram_a[16'h0001] <= 16'h0F0F;
        ram_b[16'hFFFF] <= 16'hA5A5;
        reset = 1'b1;
        mio_en_a = 1'b0; r_w_a = 1'b0; mar_a = 16'h0; mdr_a = 16'h0;
        mio_en_b = 1'b0; r_w_b = 1'b0; mar_b = 16'h0; mdr_b = 16'h0;
        tick(); tick();

        // Reset state
        chk("rst_ready", {31'd0, ready_a}, 32'd0);
        chk("rst_mem_en", {31'd0, bus_a.mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, bus_a.mem_we}, 32'd0);
        chk("rst_mem_addr", {16'd0, bus_a.mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, bus_a.mem_wdata}, 32'd0);
        chk("rst_rd_data", {16'd0, rd_a}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Read of 0x3000, WAIT_STATES=3
        mio_en_a = 1'b1; r_w_a = 1'b0; mar_a = 16'h3000;
        tick();  // E0
        mio_en_a = 1'b0;
        chk("rd_e0_mem_en", {31'd0, bus_a.mem_en}, 32'd1);
        chk("rd_e0_mem_addr", {16'd0, bus_a.mem_addr}, 32'h3000);
        chk("rd_e0_mem_we", {31'd0, bus_a.mem_we}, 32'd0);
        tick();  // E1
        chk("rd_e1_mem_en", {31'd0, bus_a.mem_en}, 32'd0);
        chk("rd_e1_ready", {31'd0, ready_a}, 32'd0);
        tick();  // E2
        chk("rd_e2_ready", {31'd0, ready_a}, 32'd0);
        tick();  // E3
        chk("rd_e3_ready", {31'd0, ready_a}, 32'd1);
        chk("rd_e3_data", {16'd0, rd_a}, 32'hBEEF);
        tick();  // E4
        chk("rd_e4_ready", {31'd0, ready_a}, 32'd0);
        tick();
        chk("rd_idle_mem_en", {31'd0, bus_a.mem_en}, 32'd0);

        // Write 0x1234 to 0x4001, then read it back
        mio_en_a = 1'b1; r_w_a = 1'b1; mar_a = 16'h4001; mdr_a = 16'h1234;
        tick();  // E0
        mio_en_a = 1'b0;
        chk("wr_e0_mem_en", {31'd0, bus_a.mem_en}, 32'd1);
        chk("wr_e0_mem_we", {31'd0, bus_a.mem_we}, 32'd1);
        chk("wr_e0_wdata", {16'd0, bus_a.mem_wdata}, 32'h1234);
        chk("wr_e0_addr", {16'd0, bus_a.mem_addr}, 32'h4001);
        tick(); tick(); tick();  // E3
        chk("wr_e3_ready", {31'd0, ready_a}, 32'd1);
        chk("wr_e3_rd_held", {16'd0, rd_a}, 32'hBEEF);
        tick();  // E4
        chk("wr_e4_mem_we", {31'd0, bus_a.mem_we}, 32'd0);
        chk("wr_count", wr_cnt_a, 32'd1);
        mio_en_a = 1'b1; r_w_a = 1'b0; mar_a = 16'h4001;
        tick();  // E0
        mio_en_a = 1'b0;
        tick(); tick(); tick();  // E3
        chk("wr_rb_ready", {31'd0, ready_a}, 32'd1);
        chk("wr_rb_data", {16'd0, rd_a}, 32'h1234);
        tick(); tick();

        // Held request for 12 cycles: acceptances at E0/E5/E10, ready at E3/E8/E13
        mio_en_a = 1'b1; r_w_a = 1'b0; mar_a = 16'h3000;
        for (int k = 0; k < 16; k++) begin
            if (k == 12) mio_en_a = 1'b0;
            tick();
            rdy_mask[k] = ready_a;
            en_mask[k]  = bus_a.mem_en;
        end
        chk("held_ready_mask", {16'd0, rdy_mask}, 32'h2108);
        chk("held_en_mask", {16'd0, en_mask}, 32'h0421);
        tick();

        // Inputs change during BUSY: only the latched read of 0x3000 happens
        wr_before = wr_cnt_a;
        mio_en_a = 1'b1; r_w_a = 1'b0; mar_a = 16'h3000;
        tick();  // E0
        mio_en_a = 1'b0; mar_a = 16'h5000; r_w_a = 1'b1; mdr_a = 16'hDEAD;
        tick();  // E1
        chk("hold_e1_addr", {16'd0, bus_a.mem_addr}, 32'h3000);
        chk("hold_e1_we", {31'd0, bus_a.mem_we}, 32'd0);
        tick(); tick();  // E3
        chk("hold_e3_ready", {31'd0, ready_a}, 32'd1);
        chk("hold_e3_data", {16'd0, rd_a}, 32'hBEEF);
        r_w_a = 1'b0;
        tick(); tick();
        chk("hold_no_write", wr_cnt_a, wr_before);
        chk("hold_ram5000", {16'd0, ram_a[16'h5000]}, 32'h5555);

        // Reset asserted between E1 and E2 of a read
        mio_en_a = 1'b1; r_w_a = 1'b0; mar_a = 16'h3000;
        tick();  // E0
        mio_en_a = 1'b0;
        tick();  // E1
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, ready_a}, 32'd0);
        chk("midrst_mem_en", {31'd0, bus_a.mem_en}, 32'd0);
        chk("midrst_rd_data", {16'd0, rd_a}, 32'd0);
        chk("midrst_mem_addr", {16'd0, bus_a.mem_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rdy_mask = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            rdy_mask[k] = ready_a;
        end
        chk("midrst_no_ready", {16'd0, rdy_mask}, 32'd0);
        mio_en_a = 1'b1; r_w_a = 1'b0; mar_a = 16'h0001;
        tick();  // E0
        mio_en_a = 1'b0;
        chk("post_e0_mem_en", {31'd0, bus_a.mem_en}, 32'd1);
        tick(); tick();  // E2
        chk("post_e2_ready", {31'd0, ready_a}, 32'd0);
        tick();  // E3
        chk("post_e3_ready", {31'd0, ready_a}, 32'd1);
        chk("post_e3_data", {16'd0, rd_a}, 32'h0F0F);
        tick();

        // Minimum latency, WAIT_STATES=2, top address 0xFFFF
        chk("min_rd_before", {16'd0, rd_b}, 32'd0);
        mio_en_b = 1'b1; r_w_b = 1'b0; mar_b = 16'hFFFF;
        tick();  // E0
        mio_en_b = 1'b0;
        chk("min_e0_addr", {16'd0, bus_b.mem_addr}, 32'hFFFF);
        tick();  // E1
        chk("min_e1_ready", {31'd0, ready_b}, 32'd0);
        tick();  // E2
        chk("min_e2_ready", {31'd0, ready_b}, 32'd1);
        chk("min_e2_data", {16'd0, rd_b}, 32'hA5A5);
        tick();  // E3
        chk("min_e3_ready", {31'd0, ready_b}, 32'd0);
        chk("min_e3_data_hold", {16'd0, rd_b}, 32'hA5A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
